inst_encode: RTL and testbench

Inverse of the instruction decoder. Takes decoded fields (op, rd, rs1, rs2, funct3, funct7, imm) and packs them into an INST_WIDTH-bit RV32I-format instruction word. It then stores that word to byte-wide instruction memory as little-endian beats, using a write/ack handshake. Used by the loader/self-modify path to emit instructions that the fetch and decode stages read back.

---
 rtl/inst_encode.sv | 242 ++++++++++++++++++++++++
 tb/tb_inst_encode.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_encode.sv
`timescale 1ns/1ps
// inst_encode: packs decoded RV32I fields (op, rd, rs1, rs2, funct3, funct7,
// imm) into one instruction word and stores it little-endian to byte-wide
// instruction memory over a write/ack handshake.
// Optional feature macro: ACK_TIMEOUT_EN -- abort the write with err=1 after
// TIMEOUT_CYCLES consecutive cycles without mem_ack.
module inst_encode #(
    parameter int unsigned M_WIDTH        = 8,
    parameter int unsigned ADDR_WIDTH     = 8,
    parameter int unsigned INST_WIDTH     = 32,
    parameter int unsigned REG_ADDR_WIDTH = 5
`ifdef ACK_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 16
`endif
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [6:0]                op,
    input  logic [REG_ADDR_WIDTH-1:0] rd,
    input  logic [REG_ADDR_WIDTH-1:0] rs1,
    input  logic [REG_ADDR_WIDTH-1:0] rs2,
    input  logic [2:0]                funct3,
    input  logic [6:0]                funct7,
    input  logic [31:0]               imm,
    input  logic [ADDR_WIDTH-1:0]     base_addr,
    output logic [INST_WIDTH-1:0]     inst,
    output logic [ADDR_WIDTH-1:0]     mem_addr,
    output logic [M_WIDTH-1:0]        mem_data,
    output logic                      mem_we,
    input  logic                      mem_ack,
    output logic                      busy,
    output logic                      ready,
    output logic                      err
);

    localparam int unsigned NBEATS = INST_WIDTH / M_WIDTH;
    localparam int unsigned BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;
`ifdef ACK_TIMEOUT_EN
    localparam int unsigned TO_W   = $clog2(TIMEOUT_CYCLES + 1);
`endif

    localparam logic [6:0] OP_LUI         = 7'b0110111;
    localparam logic [6:0] OP_AIUPC       = 7'b0010111;
    localparam logic [6:0] OP_JAL         = 7'b1101111;
    localparam logic [6:0] OP_JALR        = 7'b1100111;
    localparam logic [6:0] OP_LOAD        = 7'b0000011;
    localparam logic [6:0] OP_STORE       = 7'b0100011;
    localparam logic [6:0] OP_BRANCH      = 7'b1100011;
    localparam logic [6:0] OP_INTEGER_IMM = 7'b0010011;
    localparam logic [6:0] OP_INTEGER     = 7'b0110011;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PACK  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                      state_q;

    // Fields captured at start so the caller may change inputs while busy
    logic [6:0]                  op_q;
    logic [REG_ADDR_WIDTH-1:0]   rd_q;
    logic [REG_ADDR_WIDTH-1:0]   rs1_q;
    logic [REG_ADDR_WIDTH-1:0]   rs2_q;
    logic [2:0]                  funct3_q;
    logic [6:0]                  funct7_q;
    logic [31:0]                 imm_q;
    logic [ADDR_WIDTH-1:0]       base_q;

    logic [INST_WIDTH-1:0]       inst_q;
    logic [INST_WIDTH-1:0]       inst_d;
    logic                        pack_err_d;

    logic [ADDR_WIDTH-1:0]       mem_addr_q;
    logic [M_WIDTH-1:0]          mem_data_q;
    logic                        mem_we_q;
    logic                        busy_q;
    logic                        ready_q;
    logic                        err_q;
    logic [BEAT_W-1:0]           beat_q;
`ifdef ACK_TIMEOUT_EN
    logic [TO_W-1:0]             to_cnt_q;
`endif

    logic                        imm_fits_i;
    logic                        imm_fits_b;
    logic                        imm_fits_j;
    logic                        last_beat;
    logic [M_WIDTH-1:0]          next_data;

    // Immediate range checks: upper bits must be a pure sign extension
    assign imm_fits_i = (&imm_q[31:11]) | ~(|imm_q[31:11]);
    assign imm_fits_b = (&imm_q[31:12]) | ~(|imm_q[31:12]);
    assign imm_fits_j = (&imm_q[31:20]) | ~(|imm_q[31:20]);

    assign last_beat  = (beat_q == BEAT_W'(NBEATS - 1));
    assign next_data  = M_WIDTH'(inst_q >> ((32'(beat_q) + 32'd1) * M_WIDTH));

    // Format-dependent packing of the captured fields and legality check
    always_comb begin
        inst_d     = '0;
        pack_err_d = 1'b0;
        case (op_q)
            OP_LUI, OP_AIUPC: begin
                inst_d     = INST_WIDTH'({imm_q[31:12], rd_q, op_q});
                pack_err_d = (imm_q[11:0] != 12'd0);
            end
            OP_JAL: begin
                inst_d     = INST_WIDTH'({imm_q[20], imm_q[10:1], imm_q[11],
                                          imm_q[19:12], rd_q, op_q});
                pack_err_d = ~imm_fits_j | imm_q[0];
            end
            OP_JALR, OP_LOAD, OP_INTEGER_IMM: begin
                inst_d     = INST_WIDTH'({imm_q[11:0], rs1_q, funct3_q, rd_q, op_q});
                pack_err_d = ~imm_fits_i;
            end
            OP_STORE: begin
                inst_d     = INST_WIDTH'({imm_q[11:5], rs2_q, rs1_q, funct3_q,
                                          imm_q[4:0], op_q});
                pack_err_d = ~imm_fits_i;
            end
            OP_BRANCH: begin
                inst_d     = INST_WIDTH'({imm_q[12], imm_q[10:5], rs2_q, rs1_q,
                                          funct3_q, imm_q[4:1], imm_q[11], op_q});
                pack_err_d = ~imm_fits_b | imm_q[0];
            end
            OP_INTEGER: begin
                inst_d     = INST_WIDTH'({funct7_q, rs2_q, rs1_q, funct3_q, rd_q, op_q});
            end
            default: begin
                pack_err_d = 1'b1;
            end
        endcase
    end

    // Control FSM with registered memory-port and status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            op_q       <= '0;
            rd_q       <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            funct3_q   <= '0;
            funct7_q   <= '0;
            imm_q      <= '0;
            base_q     <= '0;
            inst_q     <= '0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            mem_we_q   <= 1'b0;
            busy_q     <= 1'b0;
            ready_q    <= 1'b0;
            err_q      <= 1'b0;
            beat_q     <= '0;
`ifdef ACK_TIMEOUT_EN
            to_cnt_q   <= '0;
`endif
        end else begin
            ready_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (en) begin
                        op_q     <= op;
                        rd_q     <= rd;
                        rs1_q    <= rs1;
                        rs2_q    <= rs2;
                        funct3_q <= funct3;
                        funct7_q <= funct7;
                        imm_q    <= imm;
                        base_q   <= base_addr;
                        err_q    <= 1'b0;
                        busy_q   <= 1'b1;
                        state_q  <= PACK;
                    end
                end
                PACK: begin
                    inst_q <= inst_d;
                    if (pack_err_d) begin
                        err_q   <= 1'b1;
                        ready_q <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        mem_we_q   <= 1'b1;
                        mem_addr_q <= base_q;
                        mem_data_q <= inst_d[M_WIDTH-1:0];
                        beat_q     <= '0;
`ifdef ACK_TIMEOUT_EN
                        to_cnt_q   <= '0;
`endif
                        state_q    <= WRITE;
                    end
                end
                WRITE: begin
                    if (mem_ack) begin
`ifdef ACK_TIMEOUT_EN
                        to_cnt_q <= '0;
`endif
                        if (last_beat) begin
                            mem_we_q <= 1'b0;
                            ready_q  <= 1'b1;
                            state_q  <= DONE;
                        end else begin
                            beat_q     <= beat_q + BEAT_W'(1);
                            mem_addr_q <= mem_addr_q + ADDR_WIDTH'(1);
                            mem_data_q <= next_data;
                        end
                    end
`ifdef ACK_TIMEOUT_EN
                    else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        err_q    <= 1'b1;
                        mem_we_q <= 1'b0;
                        ready_q  <= 1'b1;
                        state_q  <= DONE;
                    end else begin
                        to_cnt_q <= to_cnt_q + TO_W'(1);
                    end
`endif
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign inst     = inst_q;
    assign mem_addr = mem_addr_q;
    assign mem_data = mem_data_q;
    assign mem_we   = mem_we_q;
    assign busy     = busy_q;
    assign ready    = ready_q;
    assign err      = err_q;

endmodule

// File: tb/tb_inst_encode.sv
`timescale 1ns/1ps
// Scoreboard bench for inst_encode: stimulus pushes expected beats/completions,
// a negedge monitor drives mem_ack and checks what the DUT presents.
module tb_inst_encode;

    logic        clk;
    logic        rst;
    logic        en;
    logic [6:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic [7:0]  base_addr;
    logic [31:0] inst;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_data;
    logic        mem_we;
    logic        mem_ack;
    logic        busy;
    logic        ready;
    logic        err;

    inst_encode dut (
        .clk(clk), .rst(rst), .en(en), .op(op), .rd(rd), .rs1(rs1), .rs2(rs2),
        .funct3(funct3), .funct7(funct7), .imm(imm), .base_addr(base_addr),
        .inst(inst), .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we),
        .mem_ack(mem_ack), .busy(busy), .ready(ready), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]  op;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [7:0]  base;
    } txn_t;
    typedef struct { logic [7:0] addr; logic [7:0] data; } beat_t;
    typedef struct { bit e; logic [31:0] w; int left; } done_t;

    beat_t       wq[$];
    done_t       dq[$];
    int unsigned n_vec = 0;
    int unsigned n_bad = 0;
    int          ack_mode = 0;   // 0 always, 1 random, 2 three-cycle delay, 3 never
    int          wait_cnt = 0;
    int          we_cycles = 0;
    bit          in_rst = 0;
    bit          saw_ready = 0;

    logic [6:0] legal_ops [9] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
                                  7'b0000011, 7'b0100011, 7'b1100011, 7'b0010011,
                                  7'b0110011};

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endfunction

    function automatic void fail(input string nm);
        n_vec++;
        n_bad++;
        $display("FAIL %s: got event, expected none", nm);
    endfunction

    // Reference encoder: numeric range rules plus shift/mask field placement
    function automatic void model(input txn_t t, output logic [31:0] w, output bit e);
        int    s;
        logic [31:0] rd32, rs1_32, rs2_32, f3_32, op32;
        s      = $signed(t.imm);
        rd32   = 32'(t.rd)  << 7;
        rs1_32 = 32'(t.rs1) << 15;
        rs2_32 = 32'(t.rs2) << 20;
        f3_32  = 32'(t.f3)  << 12;
        op32   = 32'(t.op);
        w = 32'd0;
        e = 1'b0;
        case (t.op)
            7'b0110111, 7'b0010111: begin
                e = (t.imm % 32'd4096) != 32'd0;
                w = (t.imm & 32'hFFFF_F000) | rd32 | op32;
            end
            7'b1101111: begin
                e = (s < -1048576) || (s > 1048575) || (t.imm % 32'd2 != 32'd0);
                w = (((t.imm >> 20) & 32'h1) << 31) | (((t.imm >> 1) & 32'h3FF) << 21) |
                    (((t.imm >> 11) & 32'h1) << 20) | (((t.imm >> 12) & 32'hFF) << 12) |
                    rd32 | op32;
            end
            7'b1100111, 7'b0000011, 7'b0010011: begin
                e = (s < -2048) || (s > 2047);
                w = ((t.imm & 32'hFFF) << 20) | rs1_32 | f3_32 | rd32 | op32;
            end
            7'b0100011: begin
                e = (s < -2048) || (s > 2047);
                w = (((t.imm >> 5) & 32'h7F) << 25) | rs2_32 | rs1_32 | f3_32 |
                    ((t.imm & 32'h1F) << 7) | op32;
            end
            7'b1100011: begin
                e = (s < -4096) || (s > 4095) || (t.imm % 32'd2 != 32'd0);
                w = (((t.imm >> 12) & 32'h1) << 31) | (((t.imm >> 5) & 32'h3F) << 25) |
                    rs2_32 | rs1_32 | f3_32 | (((t.imm >> 1) & 32'hF) << 8) |
                    (((t.imm >> 11) & 32'h1) << 7) | op32;
            end
            7'b0110011: begin
                w = (32'(t.f7) << 25) | rs2_32 | rs1_32 | f3_32 | rd32 | op32;
            end
            default: e = 1'b1;
        endcase
    endfunction

    task automatic drive_fields(input txn_t t);
        op = t.op; rd = t.rd; rs1 = t.rs1; rs2 = t.rs2;
        funct3 = t.f3; funct7 = t.f7; imm = t.imm; base_addr = t.base;
    endtask

    task automatic rand_fields();
        op = 7'($urandom); rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
        funct3 = 3'($urandom); funct7 = 7'($urandom); imm = $urandom; base_addr = 8'($urandom);
    endtask

    // Issue one encode; expectations go to the scoreboard queues first
    task automatic run_txn(input txn_t t, input int mode, input bit noise,
                           input bit has_lit, input logic [31:0] lit);
        logic [31:0] w;
        bit          e;
        int          cyc;
        int          nb;
        bit          got;
        model(t, w, e);
        if (has_lit) w = lit;
        nb = e ? 0 : 4;
        if (mode == 3) begin
            nb = 1;
            e  = 1'b1;
        end
        for (int k = 0; k < nb; k++)
            wq.push_back('{addr: t.base + 8'(k), data: 8'(w >> (8 * k))});
        dq.push_back('{e: e, w: w, left: (mode == 3) ? 1 : 0});
        ack_mode = mode;
        @(negedge clk);
        drive_fields(t);
        en = 1'b1;
        we_cycles = 0;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (ready) got = 1'b1;
            if (noise && !got) begin
                rand_fields();
                en = 1'($urandom);
            end else begin
                en = 1'b0;
            end
        end
        en = 1'b0;
        if (!got) begin
            fail("ready_timeout");
        end else begin
            if (mode == 3)      chk("latency_timeout", 32'(cyc), 32'd18);
            else if (e)         chk("latency_err", 32'(cyc), 32'd2);
            else if (mode == 0) chk("latency_ok", 32'(cyc), 32'd6);
            chk("busy_in_done", 32'(busy), 32'd1);
            if (mode == 3) chk("we_cycles", 32'(we_cycles), 32'd16);
            @(negedge clk);
            chk("busy_after", 32'(busy), 32'd0);
            chk("ready_pulse", 32'(ready), 32'd0);
        end
    endtask

    // Monitor: drives mem_ack, checks presented beats and completions
    always @(negedge clk) begin
        bit    a;
        done_t d;
        if (rst || in_rst) begin
            mem_ack = 1'b0;
            wait_cnt = 0;
        end else begin
            if (mem_we) begin
                we_cycles++;
                if (wq.size() == 0) begin
                    fail("unexpected_write");
                    a = 1'b1;
                end else begin
                    chk("beat_addr", 32'(mem_addr), 32'(wq[0].addr));
                    chk("beat_data", 32'(mem_data), 32'(wq[0].data));
                    case (ack_mode)
                        0: a = 1'b1;
                        1: a = 1'($urandom);
                        2: begin
                            a = (wait_cnt == 3);
                            wait_cnt = a ? 0 : wait_cnt + 1;
                        end
                        default: a = 1'b0;
                    endcase
                    if (a) void'(wq.pop_front());
                end
                mem_ack = a;
            end else begin
                mem_ack = 1'($urandom);
                wait_cnt = 0;
            end
            if (ready) begin
                saw_ready = 1'b1;
                if (dq.size() == 0) begin
                    fail("unexpected_ready");
                end else begin
                    d = dq.pop_front();
                    chk("err", 32'(err), 32'(d.e));
                    if (!d.e) chk("inst", inst, d.w);
                    chk("beats_left", 32'(wq.size()), 32'(d.left));
                    for (int k = 0; k < d.left; k++) void'(wq.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        txn_t t;
        bit   found;
        rst = 1'b1; en = 1'b0; mem_ack = 1'b0;
        t = '{op: 7'b0010011, rd: 5'd1, rs1: 5'd0, rs2: 5'd0, f3: 3'd0, f7: 7'd0,
              imm: 32'd5, base: 8'h10};
        drive_fields(t);
        #3;
        chk("rst_inst", inst, 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_data", 32'(mem_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // addi x1,x0,5 at 0x10, ack every cycle
        run_txn(t, 0, 0, 1, 32'h0050_0093);
        // sw x2,8(x3) with slow acks
        run_txn('{op: 7'b0100011, rd: 5'd0, rs1: 5'd3, rs2: 5'd2, f3: 3'b010, f7: 7'd0,
                  imm: 32'd8, base: 8'h20}, 2, 0, 1, 32'h0021_A423);
        // beq x1,x2,-4 with stray en pulses while busy
        run_txn('{op: 7'b1100011, rd: 5'd0, rs1: 5'd1, rs2: 5'd2, f3: 3'd0, f7: 7'd0,
                  imm: 32'hFFFF_FFFC, base: 8'h30}, 1, 1, 1, 32'hFE20_8EE3);
        // illegal immediates
        run_txn('{op: 7'b1101111, rd: 5'd1, rs1: 5'd0, rs2: 5'd0, f3: 3'd0, f7: 7'd0,
                  imm: 32'd3, base: 8'h40}, 0, 0, 0, 32'd0);
        run_txn('{op: 7'b0110111, rd: 5'd1, rs1: 5'd0, rs2: 5'd0, f3: 3'd0, f7: 7'd0,
                  imm: 32'h0000_1001, base: 8'h40}, 0, 0, 0, 32'd0);
        // address wrap
        t.base = 8'hFE;
        run_txn(t, 0, 0, 1, 32'h0050_0093);

        // reset during beat 2 abandons the transfer
        for (int k = 0; k < 4; k++)
            wq.push_back('{addr: 8'hFE + 8'(k), data: 8'(32'h0050_0093 >> (8 * k))});
        dq.push_back('{e: 1'b0, w: 32'h0050_0093, left: 0});
        ack_mode = 0;
        @(negedge clk);
        drive_fields(t);
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(posedge clk);
            #2;
            if (mem_we && mem_addr == 8'h00) found = 1'b1;
        end
        if (!found) fail("beat2_timeout");
        in_rst = 1'b1;
        rst = 1'b1;
        #1;
        chk("midrst_we", 32'(mem_we), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_ready", 32'(ready), 32'd0);
        wq.delete();
        dq.delete();
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        in_rst = 1'b0;
        saw_ready = 1'b0;
        repeat (8) @(negedge clk);
        chk("no_ready_after_rst", 32'(saw_ready), 32'd0);
        t.base = 8'h50;
        run_txn(t, 1, 0, 1, 32'h0050_0093);

`ifdef ACK_TIMEOUT_EN
        t.base = 8'h60;
        run_txn(t, 3, 0, 1, 32'h0050_0093);
`endif

        // randomized encodes against the reference model
        for (int n = 0; n < 40; n++) begin
            t.op  = ($urandom_range(0, 7) == 0) ? 7'($urandom) : legal_ops[$urandom_range(0, 8)];
            t.rd  = 5'($urandom); t.rs1 = 5'($urandom); t.rs2 = 5'($urandom);
            t.f3  = 3'($urandom); t.f7  = 7'($urandom);
            t.base = 8'($urandom);
            case ($urandom_range(0, 3))
                0: t.imm = 32'($urandom_range(0, 4095)) - 32'd2048;
                1: t.imm = $urandom;
                2: t.imm = (32'($urandom_range(0, 2097151)) - 32'd1048576) & 32'hFFFF_FFFE;
                default: t.imm = 32'($urandom) << 12;
            endcase
            run_txn(t, $urandom_range(0, 2), 1'($urandom), 0, 32'd0);
        end

        repeat (3) @(negedge clk);
        chk("queues_drained", 32'(wq.size() + dq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
